// File: rtl/interface_tag_pool_pkg.sv
// Shared widths, table entry type and width helper for the tagged
// memory interface and any other tag issuers built on tag_free_list.
package interface_tag_pkg;

    localparam int def_addr_width = 64;
    localparam int def_data_width = 1024;
    localparam int def_nstrms     = 64;
    localparam int def_ntags      = 256;
    localparam int def_l2_ncl     = 256;
    localparam int def_max_outst  = 8;

    // Index width for a table of n entries; never narrower than one bit.
    function automatic int width_of(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int def_tag_width = width_of(def_ntags);
    localparam int def_sid_width = width_of(def_nstrms);
    localparam int def_ptr_width = width_of(def_l2_ncl);

    typedef struct packed {
        logic [def_sid_width-1:0] sid;
        logic [def_ptr_width-1:0] ptr;
    } tag_entry_t;

endpackage

// File: rtl/interface_tag_pool_free_list.sv
// Free-tag bit vector with lowest-index allocation, release and an
// in-use count. Allocation only ever sees the registered vector.
module tag_free_list
    import interface_tag_pkg::*;
#(
    parameter int n = def_ntags,
    localparam int w = width_of(n)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         alloc,
    input  logic         free,
    input  logic [w-1:0] free_idx,
    input  logic [w-1:0] query_idx,
    output logic         any_free,
    output logic [w-1:0] alloc_idx,
    output logic         query_free,
    output logic [w:0]   used
);

    localparam logic [w:0] one = 1;

    logic [n-1:0] free_vec;
    logic [n-1:0] free_nxt;

    always_comb begin
        any_free  = |free_vec;
        alloc_idx = '0;
        for (int i = n - 1; i >= 0; i--) begin
            if (free_vec[i]) alloc_idx = w'(i);
        end
    end

    assign query_free = free_vec[query_idx];

    always_comb begin
        free_nxt = free_vec;
        if (alloc) free_nxt[alloc_idx] = 1'b0;
        if (free)  free_nxt[free_idx]  = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            free_vec <= '1;
            used     <= '0;
        end else begin
            free_vec <= free_nxt;
            if (alloc && !free)
                used <= used + one;
            else if (free && !alloc)
                used <= used - one;
        end
    end

endmodule

// File: rtl/interface_tag_pool.sv
// Tag pool between stream cache requests and the tagged memory port;
// tracks {sid, ptr} per tag and returns responses out of order.
module interface_tag_pool
    import interface_tag_pkg::*;
#(
    parameter int addr_width = def_addr_width,
    parameter int data_width = def_data_width,
    parameter int nstrms     = def_nstrms,
    parameter int ntags      = def_ntags,
    parameter int l2_ncl     = def_l2_ncl,
    parameter int max_outst  = def_max_outst,
    localparam int nstrms_width = width_of(nstrms),
    localparam int tag_width    = width_of(ntags),
    localparam int l2_ncl_width = width_of(l2_ncl),
    localparam int cnt_width    = $clog2(max_outst + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_req_v,
    output logic                    i_req_r,
    input  logic [nstrms_width-1:0] i_req_sid,
    input  logic [addr_width-1:0]   i_req_ea,
    input  logic [l2_ncl_width-1:0] i_req_ptr,
    output logic                    o_req_v,
    input  logic                    o_req_r,
    output logic [addr_width-1:0]   o_req_ea,
    output logic [tag_width-1:0]    o_req_tag,
    input  logic                    i_rsp_v,
    output logic                    i_rsp_r,
    input  logic [tag_width-1:0]    i_rsp_tag,
    input  logic [data_width-1:0]   i_rsp_data,
    output logic                    o_rsp_v,
    input  logic                    o_rsp_r,
    output logic [data_width-1:0]   o_rsp_d,
    output logic [nstrms_width-1:0] o_rsp_sid,
    output logic [l2_ncl_width-1:0] o_rsp_ptr,
    output logic [tag_width:0]      o_outst,
    output logic                    o_err
);

    typedef struct packed {
        logic [nstrms_width-1:0] sid;
        logic [l2_ncl_width-1:0] ptr;
    } entry_t;

    localparam logic [cnt_width-1:0] cnt_max = cnt_width'(max_outst);
    localparam logic [cnt_width-1:0] cnt_one = 1;

    entry_t                 tbl [ntags];
    entry_t                 rd;
    logic [cnt_width-1:0]   cnt [nstrms];
    logic [tag_width-1:0]   alloc_idx;
    logic                   any_free;
    logic                   q_free;
    logic                   acc;
    logic                   rsp_acc;
    logic                   rel;
    logic                   spur;
    logic                   same;

    assign i_req_r = any_free && (cnt[i_req_sid] < cnt_max)
                     && (!o_req_v || o_req_r);
    assign acc     = i_req_v && i_req_r;
    assign i_rsp_r = !o_rsp_v || o_rsp_r;
    assign rsp_acc = i_rsp_v && i_rsp_r;
    assign rel     = rsp_acc && !q_free;
    assign spur    = rsp_acc && q_free;
    assign rd      = tbl[i_rsp_tag];
    assign same    = rd.sid == i_req_sid;

    tag_free_list #(.n(ntags)) u_free (
        .clk        (clk),
        .reset      (reset),
        .alloc      (acc),
        .free       (rel),
        .free_idx   (i_rsp_tag),
        .query_idx  (i_rsp_tag),
        .any_free   (any_free),
        .alloc_idx  (alloc_idx),
        .query_free (q_free),
        .used       (o_outst)
    );

    always_ff @(posedge clk) begin
        if (acc) tbl[alloc_idx] <= '{sid: i_req_sid, ptr: i_req_ptr};
    end

    // Same-stream allocate and release in one cycle leave the count as is.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < nstrms; s++) cnt[s] <= '0;
        end else begin
            if (acc && !(rel && same))
                cnt[i_req_sid] <= cnt[i_req_sid] + cnt_one;
            if (rel && !(acc && same))
                cnt[rd.sid] <= cnt[rd.sid] - cnt_one;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            o_req_v <= 1'b0;
        else if (acc)
            o_req_v <= 1'b1;
        else if (o_req_r)
            o_req_v <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (acc) begin
            o_req_ea  <= i_req_ea;
            o_req_tag <= alloc_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            o_rsp_v <= 1'b0;
        else if (rel)
            o_rsp_v <= 1'b1;
        else if (o_rsp_r)
            o_rsp_v <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rel) begin
            o_rsp_d   <= i_rsp_data;
            o_rsp_sid <= rd.sid;
            o_rsp_ptr <= rd.ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            o_err <= 1'b0;
        else if (spur)
            o_err <= 1'b1;
    end

endmodule
